// File: rtl/encode_blocker.sv
// encode_blocker
//
// Encode-side raster-to-block converter. Raster pixels are written into one of
// two strip buffers (BLOCK_SIZE rows x IMG_WIDTH pixels each). Once a strip is
// complete it is read back as consecutive BLOCK_SIZE x BLOCK_SIZE blocks, row
// major inside each block, while the other buffer is being filled.
//
// Ports:
//   clk_i            clock, all state on the rising edge
//   rst_i            asynchronous reset, active high
//   px_veri_i        raster pixel in
//   px_gecerli_i     raster pixel valid
//   px_hazir_o       ready for a raster pixel (buffer being written not full)
//   blk_veri_o       block-ordered pixel out
//   blk_row_o        row inside the current block
//   blk_col_o        column inside the current block
//   blk_gecerli_o    output valid
//   blk_blok_son_o   last pixel of a block
//   blk_serit_son_o  last pixel of the last block of a strip
//   blk_hazir_i      downstream ready

module encode_blocker #(
    parameter int PIXEL_BIT  = 8,
    parameter int BLOCK_SIZE = 8,
    parameter int IMG_WIDTH  = 640,
    localparam int BUF_LEN   = BLOCK_SIZE * IMG_WIDTH,
    localparam int BLOCK_BIT = $clog2(BLOCK_SIZE),
    localparam int NBLK      = IMG_WIDTH / BLOCK_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PIXEL_BIT-1:0] px_veri_i,
    input  logic                 px_gecerli_i,
    output logic                 px_hazir_o,
    output logic [PIXEL_BIT-1:0] blk_veri_o,
    output logic [BLOCK_BIT-1:0] blk_row_o,
    output logic [BLOCK_BIT-1:0] blk_col_o,
    output logic                 blk_gecerli_o,
    output logic                 blk_blok_son_o,
    output logic                 blk_serit_son_o,
    input  logic                 blk_hazir_i
);

    localparam int ADDR_W = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;
    localparam int BLK_W  = (NBLK > 1) ? $clog2(NBLK) : 1;

    localparam logic [ADDR_W-1:0]    LAST_WP  = ADDR_W'(BUF_LEN - 1);
    localparam logic [BLOCK_BIT-1:0] LAST_RC  = BLOCK_BIT'(BLOCK_SIZE - 1);
    localparam logic [BLK_W-1:0]     LAST_BLK = BLK_W'(NBLK - 1);

    // Strip buffers (no reset: contents are don't-care after reset)
    logic [PIXEL_BIT-1:0] r_buf0 [BUF_LEN];
    logic [PIXEL_BIT-1:0] r_buf1 [BUF_LEN];
    logic [PIXEL_BIT-1:0] r_q0;
    logic [PIXEL_BIT-1:0] r_q1;

    // Buffer bookkeeping
    logic [1:0]        r_full;
    logic [1:0]        r_issued;
    logic              r_wrSel;
    logic [ADDR_W-1:0] r_wp;
    logic              r_rdSel;

    // Read-address issue side
    logic                 r_issSel;
    logic [BLK_W-1:0]     r_blk;
    logic [BLOCK_BIT-1:0] r_row;
    logic [BLOCK_BIT-1:0] r_col;

    // BRAM read stage
    logic                 r_bValid;
    logic                 r_bSel;
    logic [BLOCK_BIT-1:0] r_bRow;
    logic [BLOCK_BIT-1:0] r_bCol;
    logic                 r_bBlkSon;
    logic                 r_bSeritSon;

    // Output register
    logic                 r_oValid;
    logic [PIXEL_BIT-1:0] r_oData;
    logic [BLOCK_BIT-1:0] r_oRow;
    logic [BLOCK_BIT-1:0] r_oCol;
    logic                 r_oBlkSon;
    logic                 r_oSeritSon;

    logic                 w_wrFire;
    logic                 w_wrLast;
    logic                 w_adv;
    logic                 w_issue;
    logic                 w_issueLast;
    logic                 w_blkSon;
    logic                 w_seritSon;
    logic                 w_release;
    logic [ADDR_W-1:0]    w_rdAddr;
    logic [PIXEL_BIT-1:0] w_bData;
    logic [1:0]           w_fullSet;
    logic [1:0]           w_fullClr;
    logic [1:0]           w_issuedSet;

    assign px_hazir_o = ~r_full[r_wrSel];
    assign w_wrFire   = px_gecerli_i & px_hazir_o;
    assign w_wrLast   = w_wrFire & (r_wp == LAST_WP);

    // The whole read pipeline moves together: when the output register is
    // empty or its pixel is being taken, every stage shifts by one.
    assign w_adv = ~r_oValid | blk_hazir_i;

    // A buffer may be issued from only once per fill; r_issued stops the
    // issue side from re-reading a strip that is still draining downstream.
    assign w_issue     = w_adv & r_full[r_issSel] & ~r_issued[r_issSel];
    assign w_blkSon    = (r_row == LAST_RC) && (r_col == LAST_RC);
    assign w_seritSon  = w_blkSon && (r_blk == LAST_BLK);
    assign w_issueLast = w_issue & w_seritSon;

    assign w_release = r_oValid & blk_hazir_i & r_oSeritSon;
    assign w_bData   = r_bSel ? r_q1 : r_q0;

    assign w_rdAddr = ADDR_W'(r_row) * ADDR_W'(IMG_WIDTH)
                    + ADDR_W'(r_blk) * ADDR_W'(BLOCK_SIZE)
                    + ADDR_W'(r_col);

    // Per-buffer set/clear requests; fill and release always target
    // different buffers, so both can land in the same cycle.
    always_comb begin
        w_fullSet   = '0;
        w_fullClr   = '0;
        w_issuedSet = '0;
        if (w_wrLast) begin
            w_fullSet[r_wrSel] = 1'b1;
        end
        if (w_release) begin
            w_fullClr[r_rdSel] = 1'b1;
        end
        if (w_issueLast) begin
            w_issuedSet[r_issSel] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_full   <= '0;
            r_issued <= '0;
            r_rdSel  <= 1'b0;
        end else begin
            r_full   <= (r_full & ~w_fullClr) | w_fullSet;
            r_issued <= (r_issued & ~w_fullClr) | w_issuedSet;
            if (w_release) begin
                r_rdSel <= ~r_rdSel;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wp    <= '0;
            r_wrSel <= 1'b0;
        end else if (w_wrFire) begin
            if (r_wp == LAST_WP) begin
                r_wp    <= '0;
                r_wrSel <= ~r_wrSel;
            end else begin
                r_wp <= r_wp + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wrFire && !r_wrSel) begin
            r_buf0[r_wp] <= px_veri_i;
        end
        if (w_issue && !r_issSel) begin
            r_q0 <= r_buf0[w_rdAddr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wrFire && r_wrSel) begin
            r_buf1[r_wp] <= px_veri_i;
        end
        if (w_issue && r_issSel) begin
            r_q1 <= r_buf1[w_rdAddr];
        end
    end

    // Scan counters: column fastest, then row, then block. Finishing the
    // last address of a strip switches to the other buffer immediately so
    // the prefetch can run straight into the next strip.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_issSel <= 1'b0;
            r_blk    <= '0;
            r_row    <= '0;
            r_col    <= '0;
        end else if (w_issue) begin
            if (r_col != LAST_RC) begin
                r_col <= r_col + BLOCK_BIT'(1);
            end else begin
                r_col <= '0;
                if (r_row != LAST_RC) begin
                    r_row <= r_row + BLOCK_BIT'(1);
                end else begin
                    r_row <= '0;
                    if (r_blk != LAST_BLK) begin
                        r_blk <= r_blk + BLK_W'(1);
                    end else begin
                        r_blk    <= '0;
                        r_issSel <= ~r_issSel;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bValid    <= 1'b0;
            r_bSel      <= 1'b0;
            r_bRow      <= '0;
            r_bCol      <= '0;
            r_bBlkSon   <= 1'b0;
            r_bSeritSon <= 1'b0;
        end else if (w_adv) begin
            r_bValid <= w_issue;
            if (w_issue) begin
                r_bSel      <= r_issSel;
                r_bRow      <= r_row;
                r_bCol      <= r_col;
                r_bBlkSon   <= w_blkSon;
                r_bSeritSon <= w_seritSon;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_oValid    <= 1'b0;
            r_oData     <= '0;
            r_oRow      <= '0;
            r_oCol      <= '0;
            r_oBlkSon   <= 1'b0;
            r_oSeritSon <= 1'b0;
        end else if (w_adv) begin
            r_oValid <= r_bValid;
            if (r_bValid) begin
                r_oData     <= w_bData;
                r_oRow      <= r_bRow;
                r_oCol      <= r_bCol;
                r_oBlkSon   <= r_bBlkSon;
                r_oSeritSon <= r_bSeritSon;
            end
        end
    end

    assign blk_veri_o      = r_oData;
    assign blk_row_o       = r_oRow;
    assign blk_col_o       = r_oCol;
    assign blk_gecerli_o   = r_oValid;
    assign blk_blok_son_o  = r_oValid & r_oBlkSon;
    assign blk_serit_son_o = r_oValid & r_oSeritSon;

endmodule
